// File: rtl/worley_pkg.sv
// Shared definitions for the Worley noise engine.
//   - mode_e       : shade selection (F1, F2, F2-F1 edge, cell id)
//   - dist_w()     : width of a squared distance for a given coordinate width
//   - init_x/y()   : reset position of feature point i
//   - init_vx/vy() : reset velocity of feature point i
package worley_pkg;

  typedef enum logic [1:0] {
    MODE_F1   = 2'd0,
    MODE_F2   = 2'd1,
    MODE_EDGE = 2'd2,
    MODE_CELL = 2'd3
  } mode_e;

  localparam int COORD_W_DEFAULT = 10;
  localparam int DIST_W          = 2 * COORD_W_DEFAULT + 1;

  // dx^2 + dy^2 needs one bit more than a single square.
  function automatic int dist_w(input int coord_w);
    return 2 * coord_w + 1;
  endfunction

  function automatic int init_x(input int i, input int h_res);
    return (97 + 163 * i) % h_res;
  endfunction

  function automatic int init_y(input int i, input int v_res);
    return (53 + 127 * i) % v_res;
  endfunction

  function automatic int init_vx(input int i);
    return ((i % 2 == 0) ? 1 : -1) * (1 + i % 3);
  endfunction

  function automatic int init_vy(input int i);
    return ((i % 2 == 1) ? 1 : -1) * (1 + (i + 1) % 3);
  endfunction

endpackage

// File: rtl/worley_point_mover.sv
// One feature point: position and velocity registers with edge bounce.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (loads init position)
//   step         : advance one frame of motion this cycle
//   pos_x, pos_y : current position
module worley_point_mover
  import worley_pkg::*;
#(
  parameter int IDX     = 0,
  parameter int COORD_W = 10,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y
);

  localparam int VEL_W = 4;
  // Two extra bits: one for sign, one so p + v never wraps.
  localparam int SUM_W = COORD_W + 2;

  localparam logic [COORD_W-1:0]      INIT_X  = COORD_W'(init_x(IDX, H_RES));
  localparam logic [COORD_W-1:0]      INIT_Y  = COORD_W'(init_y(IDX, V_RES));
  localparam logic signed [VEL_W-1:0] INIT_VX = VEL_W'(init_vx(IDX));
  localparam logic signed [VEL_W-1:0] INIT_VY = VEL_W'(init_vy(IDX));
  localparam logic signed [SUM_W-1:0] MAX_X   = SUM_W'(H_RES - 1);
  localparam logic signed [SUM_W-1:0] MAX_Y   = SUM_W'(V_RES - 1);

  logic signed [VEL_W-1:0] vel_x;
  logic signed [VEL_W-1:0] vel_y;
  logic signed [SUM_W-1:0] next_x;
  logic signed [SUM_W-1:0] next_y;
  logic                    bounce_x;
  logic                    bounce_y;

  always_comb begin
    next_x   = $signed({2'b00, pos_x} + {{(SUM_W-VEL_W){vel_x[VEL_W-1]}}, vel_x});
    next_y   = $signed({2'b00, pos_y} + {{(SUM_W-VEL_W){vel_y[VEL_W-1]}}, vel_y});
    bounce_x = next_x[SUM_W-1] || (next_x > MAX_X);
    bounce_y = next_y[SUM_W-1] || (next_y > MAX_Y);
  end

  // On a bounce the velocity flips and the position holds for this frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x <= INIT_X;
      pos_y <= INIT_Y;
      vel_x <= INIT_VX;
      vel_y <= INIT_VY;
    end else if (step) begin
      if (bounce_x) vel_x <= -vel_x;
      else          pos_x <= next_x[COORD_W-1:0];
      if (bounce_y) vel_y <= -vel_y;
      else          pos_y <= next_y[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/worley_noise_engine.sv
// Pipelined Worley (cellular) noise for the VGA pixel path, latency 4.
// Ports:
//   clk, rst_n  : pixel clock, synchronous active-low reset
//   frame_tick  : one pulse per frame, steps point motion (unless freeze)
//   freeze      : hold all points
//   pix_valid   : display_on for x, y
//   x, y        : pixel coordinate
//   mode        : 0=F1, 1=F2, 2=F2-F1, 3=cell id
//   noise       : 8-bit shade (0 when noise_valid=0)
//   noise_valid : pix_valid delayed by 4 cycles
module worley_noise_engine
  import worley_pkg::*;
#(
  parameter int NUM_POINTS = 4,
  parameter int COORD_W    = 10,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int DIST_SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               freeze,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         mode,
  output logic [7:0]         noise,
  output logic               noise_valid
);

  localparam int DW        = dist_w(COORD_W);
  localparam int IDX_W     = $clog2(NUM_POINTS);
  localparam int CELL_STEP = 256 / NUM_POINTS;

  logic step;
  assign step = frame_tick & ~freeze;

  logic [COORD_W-1:0] pt_x [NUM_POINTS];
  logic [COORD_W-1:0] pt_y [NUM_POINTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_POINTS; gi++) begin : g_mover
      worley_point_mover #(
        .IDX     (gi),
        .COORD_W (COORD_W),
        .H_RES   (H_RES),
        .V_RES   (V_RES)
      ) u_mover (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .pos_x (pt_x[gi]),
        .pos_y (pt_y[gi])
      );
    end
  endgenerate

  // Pipeline registers. Only the valid bits and the output are reset;
  // data registers are qualified by their valid bit.
  logic               s1_valid, s2_valid, s3_valid;
  mode_e              s1_mode, s2_mode, s3_mode;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic [COORD_W-1:0] s1_px [NUM_POINTS];
  logic [COORD_W-1:0] s1_py [NUM_POINTS];
  logic [COORD_W-1:0] s2_dx [NUM_POINTS];
  logic [COORD_W-1:0] s2_dy [NUM_POINTS];
  logic [DW-1:0]      s3_dist [NUM_POINTS];

  // The S1 snapshot is taken on the same edge that applies motion, so a
  // pixel captured during a tick cycle sees the old positions.
  always_ff @(posedge clk) begin
    s1_x    <= x;
    s1_y    <= y;
    s1_mode <= mode_e'(mode);
    s2_mode <= s1_mode;
    s3_mode <= s2_mode;
    for (int i = 0; i < NUM_POINTS; i++) begin
      s1_px[i]   <= pt_x[i];
      s1_py[i]   <= pt_y[i];
      s2_dx[i]   <= (s1_x >= s1_px[i]) ? s1_x - s1_px[i] : s1_px[i] - s1_x;
      s2_dy[i]   <= (s1_y >= s1_py[i]) ? s1_y - s1_py[i] : s1_py[i] - s1_y;
      s3_dist[i] <= DW'(s2_dx[i]) * DW'(s2_dx[i]) + DW'(s2_dy[i]) * DW'(s2_dy[i]);
    end
  end

  // S4: linear F1/F2 reduction in index order. Strict '<' keeps the lower
  // index as F1 on a tie, and the tied value then lands in F2.
  logic [DW-1:0]    f1, f2, metric, shifted;
  logic [IDX_W-1:0] idx1;
  logic [7:0]       sat, shade;

  always_comb begin
    f1   = s3_dist[0];
    f2   = '1;
    idx1 = '0;
    for (int i = 1; i < NUM_POINTS; i++) begin
      if (s3_dist[i] < f1) begin
        f2   = f1;
        f1   = s3_dist[i];
        idx1 = IDX_W'(i);
      end else if (s3_dist[i] < f2) begin
        f2 = s3_dist[i];
      end
    end

    case (s3_mode)
      MODE_F1: metric = f1;
      MODE_F2: metric = f2;
      default: metric = f2 - f1;
    endcase
    shifted = metric >> DIST_SHIFT;
    sat     = (shifted > DW'(255)) ? 8'hFF : shifted[7:0];

    case (s3_mode)
      MODE_F1, MODE_F2: shade = 8'hFF - sat;
      MODE_EDGE:        shade = sat;
      // Truncation to 8 bits is the intended [7:0] of idx1 * step.
      default:          shade = 8'(idx1) * 8'(CELL_STEP);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      noise_valid <= 1'b0;
      noise       <= 8'h00;
    end else begin
      s1_valid    <= pix_valid;
      s2_valid    <= s1_valid;
      s3_valid    <= s2_valid;
      noise_valid <= s3_valid;
      noise       <= s3_valid ? shade : 8'h00;
    end
  end

endmodule

// File: tb/tb_worley_noise_engine.sv
// Self-checking bench: a 4-point and a 2-point engine share all inputs.
// A frame-level model of the points and a sort-based F1/F2 reference give
// the expected shade; expectations ride a 4-deep queue to match latency.
module tb_worley_noise_engine;

  localparam int CW = 10;
  localparam int HR = 640;
  localparam int VR = 480;
  localparam int SH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          freeze = 1'b0;
  logic          pix_valid = 1'b0;
  logic [CW-1:0] x = '0;
  logic [CW-1:0] y = '0;
  logic [1:0]    mode = '0;
  logic [7:0]    noise4, noise2;
  logic          nv4, nv2;

  always #5 clk = ~clk;

  worley_noise_engine #(.NUM_POINTS(4), .COORD_W(CW), .H_RES(HR), .V_RES(VR), .DIST_SHIFT(SH)) dut4 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .freeze(freeze), .pix_valid(pix_valid),
    .x(x), .y(y), .mode(mode), .noise(noise4), .noise_valid(nv4)
  );

  worley_noise_engine #(.NUM_POINTS(2), .COORD_W(CW), .H_RES(HR), .V_RES(VR), .DIST_SHIFT(SH)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .freeze(freeze), .pix_valid(pix_valid),
    .x(x), .y(y), .mode(mode), .noise(noise2), .noise_valid(nv2)
  );

  int total = 0;
  int bad = 0;

  int mx[16], my[16], mvx[16], mvy[16];

  typedef struct packed {
    logic       v;
    logic [7:0] n4;
    logic [7:0] n2;
  } exp_t;
  exp_t expq[$];
  bit   check_en = 1'b0;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mx[i]  = (97 + 163 * i) % HR;
      my[i]  = (53 + 127 * i) % VR;
      mvx[i] = ((i % 2 == 0) ? 1 : -1) * (1 + i % 3);
      mvy[i] = ((i % 2 == 1) ? 1 : -1) * (1 + (i + 1) % 3);
    end
  endfunction

  function automatic void model_tick();
    int n;
    for (int i = 0; i < 16; i++) begin
      n = mx[i] + mvx[i];
      if (n < 0 || n > HR - 1) mvx[i] = -mvx[i];
      else mx[i] = n;
      n = my[i] + mvy[i];
      if (n < 0 || n > VR - 1) mvy[i] = -mvy[i];
      else my[i] = n;
    end
  endfunction

  // Reference shade: sort all squared distances; F1/F2 are the two smallest,
  // idx1 is the first point holding F1.
  function automatic int ref_noise(input int px, input int py, input int md, input int n);
    int d[$];
    int s[$];
    int f1, f2, idx, v, sh;
    for (int i = 0; i < n; i++)
      d.push_back((px - mx[i]) * (px - mx[i]) + (py - my[i]) * (py - my[i]));
    s = d;
    s.sort();
    f1  = s[0];
    f2  = s[1];
    idx = 0;
    for (int i = n - 1; i >= 0; i--)
      if (d[i] == f1) idx = i;
    v  = (md == 0) ? f1 : (md == 1) ? f2 : f2 - f1;
    sh = v >> SH;
    if (sh > 255) sh = 255;
    if (md == 3) return (idx * (256 / n)) % 256;
    if (md == 2) return sh;
    return 255 - sh;
  endfunction

  // One clock: drive inputs, predict, clock, then compare the output that
  // corresponds to the pixel driven three edges earlier.
  task automatic step(input bit pv, input int px, input int py, input int md,
                      input bit tick, input bit frz, input bit rst_in);
    exp_t e;
    pix_valid  = pv;
    x          = CW'(px);
    y          = CW'(py);
    mode       = 2'(md);
    frame_tick = tick;
    freeze     = frz;
    rst_n      = rst_in;
    e.v  = pv;
    e.n4 = pv ? 8'(ref_noise(px, py, md, 4)) : 8'h00;
    e.n2 = pv ? 8'(ref_noise(px, py, md, 2)) : 8'h00;
    @(posedge clk);
    if (!rst_in) begin
      model_reset();
      expq.delete();
      repeat (4) expq.push_back('0);
      check_en = 1'b1;
    end else begin
      void'(expq.pop_front());
      expq.push_back(e);
      if (tick && !frz) model_tick();
    end
    #1;
    if (check_en) begin
      check("valid4", int'(nv4), int'(expq[0].v));
      check("noise4", int'(noise4), int'(expq[0].n4));
      check("valid2", int'(nv2), int'(expq[0].v));
      check("noise2", int'(noise2), int'(expq[0].n2));
      if (expq[0].v)
        $display("pixel out: noise4=%0d noise2=%0d", noise4, noise2);
    end
    @(negedge clk);
  endtask

  // Directed pixel followed by three idle cycles; compare against constants.
  task automatic probe(input string tag, input int px, input int py, input int md,
                       input int want4, input int want2);
    step(1'b1, px, py, md, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    $display("probe %s (%0d,%0d) mode %0d: noise4=%0d noise2=%0d valid=%0d",
             tag, px, py, md, noise4, noise2, nv4);
    check({tag, "_valid"}, int'(nv4), 1);
    if (want4 >= 0) check({tag, "_n4"}, int'(noise4), want4);
    if (want2 >= 0) check({tag, "_n2"}, int'(noise2), want2);
  endtask

  initial begin
    @(negedge clk);
    repeat (2) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", int'(nv4), 0);
    check("reset_noise", int'(noise4), 0);

    // Initial points: p0 (97,53), p1 (260,180), p2 (423,307), p3 (586,434).
    probe("f1_on_p0",   97,  53, 0, 255, 255);
    probe("f1_d256",   113,  53, 0, 254, 254);
    probe("f2",         97,  53, 1,  89,  89);
    probe("edge",       97,  53, 2, 166, 166);
    probe("cell0",      97,  53, 3,   0,   0);
    probe("cell1",     260, 180, 3,  64, 128);
    // Equidistant from p0 and p1 (d=21349 each): tie goes to index 0.
    probe("tie_edge",  115, 198, 2,  -1,   0);
    probe("tie_cell",  115, 198, 3,  -1,   0);
    probe("tie_f1",    115, 198, 0,  -1, 172);

    // Pixel stream with gaps.
    for (int i = 0; i < 10; i++)
      step(i % 3 != 0, 90 + 3 * i, 50 + i, i % 4, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Bounce of point 0 on the top edge with back-to-back ticks.
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (26) step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    probe("tick26", 123, 1, 0, 255, 255);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    probe("tick27", 124, 1, 0, 255, 255);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    probe("tick28", 125, 3, 0, 255, 255);

    // Freeze holds points.
    repeat (5) step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    probe("frozen", 125, 3, 0, 255, 255);

    // Reset with the pipeline full.
    for (int i = 0; i < 3; i++) step(1'b1, 100 + i, 60, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 103, 60, 0, 1'b0, 1'b0, 1'b0);
    check("midrst_valid", int'(nv4), 0);
    check("midrst_noise", int'(noise4), 0);
    probe("after_rst", 97, 53, 0, 255, 255);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 499) != 0));
    end
    repeat (4) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
